// File: rtl/sram_responder.sv
// Cycle-accurate responder for the external 32-bit async SRAM: owns the array, enforces hold timing.
// Optional protocol checker enabled by defining SRAM_RESP_PROTO_CHK_EN.
module sram_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 17,
  parameter int DEPTH      = 131072,
  parameter int RD_LATENCY = 2,
  parameter int WR_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  input  logic              SRAM_WE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_CE_N,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count,
  output logic              proto_err
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WR_LAST = 4'(WR_CYCLES - 1);
  localparam logic [3:0] RD_LAST = 4'(RD_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_DONE, RD_WAIT, RD_DRIVE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] dq_out;
  logic              dq_oe;
  logic [DATA_W-1:0] mem [DEPTH];

  logic             wrq, rrq, same, reeval;
  logic [IDX_W-1:0] idx, lat_idx;

  // Write wins when WE_N and OE_N are both low.
  assign wrq     = !SRAM_CE_N && !SRAM_WE_N;
  assign rrq     = !SRAM_CE_N &&  SRAM_WE_N && !SRAM_OE_N;
  assign same    = (SRAM_ADDR == lat_addr);
  assign idx     = SRAM_ADDR[IDX_W-1:0];
  assign lat_idx = lat_addr[IDX_W-1:0];

  // States that treat the current edge like a fresh request from IDLE.
  always_comb begin
    reeval = 1'b0;
    case (state)
      IDLE:     reeval = 1'b1;
      WR_DONE:  reeval = !(wrq && same);
      RD_DRIVE: reeval = !rrq;
      default:  reeval = 1'b0;
    endcase
  end

  assign SRAM_DQ = dq_oe ? dq_out : {DATA_W{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      dq_oe    <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (reeval) begin
      dq_oe <= 1'b0;
      if (wrq) begin
        lat_addr <= SRAM_ADDR;
        cnt      <= 4'd1;
        if (WR_CYCLES == 1) begin
          mem[idx] <= SRAM_DQ;
          wr_count <= wr_count + 16'd1;
          state    <= WR_DONE;
        end else begin
          state <= WR_WAIT;
        end
      end else if (rrq) begin
        lat_addr <= SRAM_ADDR;
        cnt      <= 4'd1;
        if (RD_LATENCY == 1) begin
          dq_out   <= mem[idx];
          dq_oe    <= 1'b1;
          rd_count <= rd_count + 16'd1;
          state    <= RD_DRIVE;
        end else begin
          state <= RD_WAIT;
        end
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        WR_WAIT: begin
          if (!wrq) begin
            state <= IDLE;
          end else if (!same) begin
            lat_addr <= SRAM_ADDR;
            cnt      <= 4'd1;
          end else if (cnt == WR_LAST) begin
            mem[lat_idx] <= SRAM_DQ;
            wr_count     <= wr_count + 16'd1;
            cnt          <= cnt + 4'd1;
            state        <= WR_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_WAIT: begin
          if (!rrq) begin
            state <= IDLE;
          end else if (!same) begin
            lat_addr <= SRAM_ADDR;
            cnt      <= 4'd1;
          end else if (cnt == RD_LAST) begin
            dq_out   <= mem[lat_idx];
            dq_oe    <= 1'b1;
            rd_count <= rd_count + 16'd1;
            cnt      <= cnt + 4'd1;
            state    <= RD_DRIVE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_DRIVE: begin
          // Only reached with RRQ held; a single-edge latency re-drives in place.
          if (!same) begin
            lat_addr <= SRAM_ADDR;
            cnt      <= 4'd1;
            if (RD_LATENCY == 1) begin
              dq_out   <= mem[idx];
              rd_count <= rd_count + 16'd1;
            end else begin
              dq_oe <= 1'b0;
              state <= RD_WAIT;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SRAM_RESP_PROTO_CHK_EN
  logic commit;
  assign commit = reeval ? (wrq && (WR_CYCLES == 1))
                         : (state == WR_WAIT && wrq && same && cnt == WR_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      proto_err <= 1'b0;
    end else begin
      if (!SRAM_CE_N && !SRAM_WE_N && !SRAM_OE_N) begin
        proto_err <= 1'b1;
        $display("sram_responder: WE_N and OE_N both low at addr %h", SRAM_ADDR);
      end
      if (state == WR_WAIT && wrq && !same) begin
        proto_err <= 1'b1;
        $display("sram_responder: address moved during write hold (%h -> %h)", lat_addr, SRAM_ADDR);
      end
      if (commit && $isunknown(SRAM_DQ)) begin
        proto_err <= 1'b1;
        $display("sram_responder: unknown data on DQ at commit, addr %h", SRAM_ADDR);
      end
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Table-driven bench for sram_responder with a read-data scoreboard queue and corner-case sequences.
module tb_sram_responder;
  localparam int DW  = 32;
  localparam int AW  = 17;
  localparam int RDL = 2;
  localparam int WRC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wire  [DW-1:0] dq;
  logic [DW-1:0] tb_dq;
  logic          tb_oe;
  logic [AW-1:0] addr;
  logic          we_n, oe_n, ce_n;
  logic [15:0]   rd_count, wr_count;
  logic          proto_err;

  assign dq = tb_oe ? tb_dq : {DW{1'bz}};

  sram_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(131072), .RD_LATENCY(RDL), .WR_CYCLES(WRC)
  ) dut (
    .clk(clk), .rst(rst), .SRAM_DQ(dq), .SRAM_ADDR(addr),
    .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
    .rd_count(rd_count), .wr_count(wr_count), .proto_err(proto_err)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int exp_rd = 0;
  int exp_wr = 0;
  logic [DW-1:0] sb_q[$];

`ifdef SRAM_RESP_PROTO_CHK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] a;
    logic [DW-1:0] val;   // write data, or expected read data
    int            hold;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; tb_oe = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    @(negedge clk);
    addr = a; tb_dq = d; tb_oe = 1'b1; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    bus_idle();
    if (hold >= WRC) exp_wr++;
    chk("wr_count", 32'(wr_count), 32'(exp_wr));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input int hold);
    logic [DW-1:0] e;
    sb_q.push_back(exp);
    @(negedge clk);
    addr = a; tb_oe = 1'b0; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    repeat (RDL - 1) @(posedge clk);
    #1 chk("rd_early_oe", 32'(dut.dq_oe), 32'd0);
    @(posedge clk);
    #1 exp_rd++;
    e = sb_q.pop_front();
    chk("rd_data", dq, e);
    chk("rd_count", 32'(rd_count), 32'(exp_rd));
    if (hold > RDL) begin
      repeat (hold - RDL) @(posedge clk);
      #1 chk("rd_hold_data", dq, e);
      chk("rd_hold_count", 32'(rd_count), 32'(exp_rd));
    end
    @(negedge clk);
    bus_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] e;
    vecs[0] = '{1'b1, 17'h00010,  32'hDEADBEEF, 2};
    vecs[1] = '{1'b0, 17'h00010,  32'hDEADBEEF, 2};
    vecs[2] = '{1'b1, 17'h00020,  32'h11112222, 2};
    vecs[3] = '{1'b1, 17'h00030,  32'h00000001, 10};
    vecs[4] = '{1'b0, 17'h00030,  32'h00000001, 4};
    vecs[5] = '{1'b1, 17'h00040,  32'hA5A50040, 3};
    vecs[6] = '{1'b1, 17'h00041,  32'h5A5A0041, 2};
    vecs[7] = '{1'b1, 17'h1FFFF,  32'hFFFF0000, 2};
    vecs[8] = '{1'b0, 17'h1FFFF,  32'hFFFF0000, 2};
    vecs[9] = '{1'b0, 17'h00020,  32'h11112222, 3};

    bus_idle();
    addr = '0; tb_dq = '0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_count", 32'(rd_count), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_dq_oe", 32'(dut.dq_oe), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) do_write(vecs[i].a, vecs[i].val, vecs[i].hold);
      else               do_read(vecs[i].a, vecs[i].val, vecs[i].hold);
    end

    // Aborted write: one edge only, old contents must survive.
    do_write(17'h00020, 32'hDEAD0020, 1);
    do_read(17'h00020, 32'h11112222, 2);

    // Address change while driving.
    sb_q.push_back(32'hA5A50040);
    @(negedge clk);
    addr = 17'h00040; tb_oe = 1'b0; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 exp_rd++;
    e = sb_q.pop_front();
    chk("chg_first_data", dq, e);
    @(negedge clk);
    addr = 17'h00041;
    sb_q.push_back(32'h5A5A0041);
    @(posedge clk);
    #1 chk("chg_release", 32'(dut.dq_oe), 32'd0);
    @(posedge clk);
    #1 exp_rd++;
    e = sb_q.pop_front();
    chk("chg_second_data", dq, e);
    chk("chg_rd_count", 32'(rd_count), 32'(exp_rd));
    @(negedge clk);
    bus_idle();

    chk("perr_before_weoe", 32'(proto_err), 32'd0);

    // WE_N and OE_N low together: a write, bus never driven by the responder.
    @(negedge clk);
    addr = 17'h00050; tb_dq = 32'h50505050; tb_oe = 1'b1; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 chk("weoe_no_drive", 32'(dut.dq_oe), 32'd0);
    end
    @(negedge clk);
    bus_idle();
    exp_wr++;
    chk("weoe_wr_count", 32'(wr_count), 32'(exp_wr));
    chk("weoe_proto_err", 32'(proto_err), 32'(EXP_PERR));
    do_read(17'h00050, 32'h50505050, 2);

    // Reset in the middle of a write hold.
    do_write(17'h00060, 32'h66666666, 2);
    @(negedge clk);
    addr = 17'h00060; tb_dq = 32'h77777777; tb_oe = 1'b1; ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_rd_count", 32'(rd_count), 32'd0);
    chk("mid_rst_wr_count", 32'(wr_count), 32'd0);
    chk("mid_rst_dq_oe", 32'(dut.dq_oe), 32'd0);
    chk("mid_rst_proto_err", 32'(proto_err), 32'd0);
    exp_rd = 0;
    exp_wr = 0;
    @(negedge clk);
    rst = 1'b1;
    bus_idle();
    do_read(17'h00060, 32'h66666666, 2);
    do_read(17'h00010, 32'hDEADBEEF, 2);
    do_write(17'h00061, 32'h12345678, 2);
    do_read(17'h00061, 32'h12345678, 2);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
